// File: rtl/cfg_frame_sr.sv
// Column config chain serialiser: loads a frame of NWORDS words of LEN bits and sends it
// one bit at a time, each bit strobed once and held until the column acknowledges it.
module cfg_frame_sr #(
   parameter int unsigned LEN       = 7,
   parameter int unsigned NWORDS    = 4,
   parameter bit          MSB_FIRST = 1'b1,
   localparam int unsigned IDX_W    = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
   input  logic                   clk,
   input  logic                   i_rst,
   input  logic                   i_load,
   input  logic [NWORDS*LEN-1:0]  i_data,
   input  logic                   i_col_rdy,
   input  logic                   i_abort,
   output logic                   o_col_write,
   output logic                   o_data,
   output logic                   o_word_end,
   output logic [IDX_W-1:0]       o_word_idx,
   output logic                   o_ready,
   output logic                   o_done
);

   localparam int unsigned CNT_W = $clog2(LEN);

   typedef enum logic [2:0] {StIdle, StWrite, StWait, StShift, StDone} state_e;

   state_e                state_q, state_d;
   logic [NWORDS*LEN-1:0] frame_q, frame_d;
   logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
   logic [IDX_W-1:0]      word_cnt_q, word_cnt_d;
   logic [LEN-1:0]        cur_word, shifted_word;
   logic                  cur_bit, last_bit, last_word;

   // Constant-index mux keeps the word select free of variable part-selects.
   always_comb begin
      cur_word = '0;
      for (int k = 0; k < NWORDS; k++) begin
         if (word_cnt_q == IDX_W'(k)) begin
            cur_word = frame_q[k*LEN +: LEN];
         end
      end
   end

   always_comb begin
      if (MSB_FIRST) begin
         shifted_word = {cur_word[LEN-2:0], 1'b0};
      end else begin
         shifted_word = {1'b0, cur_word[LEN-1:1]};
      end
   end

   assign cur_bit   = MSB_FIRST ? cur_word[LEN-1] : cur_word[0];
   assign last_bit  = (bit_cnt_q == '0);
   assign last_word = (word_cnt_q == IDX_W'(NWORDS - 1));

   always_comb begin
      state_d     = state_q;
      frame_d     = frame_q;
      bit_cnt_d   = bit_cnt_q;
      word_cnt_d  = word_cnt_q;
      o_col_write = 1'b0;
      o_data      = 1'b0;
      o_word_end  = 1'b0;
      o_ready     = 1'b0;
      o_done      = 1'b0;

      unique case (state_q)
         StIdle: begin
            o_ready = 1'b1;
            if (i_load) begin
               frame_d    = i_data;
               bit_cnt_d  = CNT_W'(LEN - 1);
               word_cnt_d = '0;
               state_d    = StWrite;
            end
         end
         StWrite: begin
            o_col_write = 1'b1;
            o_data      = cur_bit;
            o_word_end  = last_bit;
            state_d     = StWait;
         end
         StWait: begin
            o_data = cur_bit;
            if (i_col_rdy) begin
               state_d = (last_bit && last_word) ? StDone : StShift;
            end
         end
         StShift: begin
            o_data = cur_bit;
            for (int k = 0; k < NWORDS; k++) begin
               if (word_cnt_q == IDX_W'(k)) begin
                  frame_d[k*LEN +: LEN] = shifted_word;
               end
            end
            if (last_bit) begin
               bit_cnt_d  = CNT_W'(LEN - 1);
               word_cnt_d = word_cnt_q + IDX_W'(1);
            end else begin
               bit_cnt_d = bit_cnt_q - CNT_W'(1);
            end
            state_d = StWrite;
         end
         StDone: begin
            o_done  = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      // Abort freezes the frame and counters and wins over any acknowledge.
      if (i_abort && (state_q != StIdle)) begin
         state_d    = StIdle;
         frame_d    = frame_q;
         bit_cnt_d  = bit_cnt_q;
         word_cnt_d = word_cnt_q;
      end
   end

   assign o_word_idx = word_cnt_q;

   always_ff @(posedge clk) begin
      if (i_rst) begin
         state_q    <= StIdle;
         frame_q    <= '0;
         bit_cnt_q  <= CNT_W'(LEN - 1);
         word_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         frame_q    <= frame_d;
         bit_cnt_q  <= bit_cnt_d;
         word_cnt_q <= word_cnt_d;
      end
   end

endmodule
